// File: rtl/fwd_wb_unit_pkg.sv
// Shared types for the forwarding / write-back unit.
// Load width encodings, pipeline slot structs and the x0 index.
package fwd_wb_unit_pkg;

    localparam int XLEN_D      = 32;
    localparam int NREG_BITS_D = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [NREG_BITS_D-1:0] X0 = '0;

    typedef struct packed {
        logic                   v;
        logic [NREG_BITS_D-1:0] rd;
        logic                   we;
        logic                   ld;
        logic                   st;
        logic [2:0]             funct3;
        logic [XLEN_D-1:0]      dat;
    } mem_slot_t;

    typedef struct packed {
        logic                   v;
        logic [NREG_BITS_D-1:0] rd;
        logic                   we;
        logic [XLEN_D-1:0]      dat;
    } wb_slot_t;

endpackage

// File: rtl/fwd_wb_unit_ld_align.sv
// Load data alignment: picks byte/half by address offset
// and sign- or zero-extends according to funct3.
module fwd_wb_unit_ld_align
    import fwd_wb_unit_pkg::*;
(
    input  logic [2:0]        funct3,
    input  logic [1:0]        off,
    input  logic [XLEN_D-1:0] rdat,
    output logic [XLEN_D-1:0] dat
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b   = rdat[{off, 3'b000} +: 8];
        h   = rdat[{off[1], 4'b0000} +: 16];
        dat = rdat;
        unique case (funct3)
            F3_LB:   dat = {{24{b[7]}}, b};
            F3_LH:   dat = {{16{h[15]}}, h};
            F3_LBU:  dat = {24'h0, b};
            F3_LHU:  dat = {16'h0, h};
            F3_LW:   dat = rdat;
            default: dat = rdat;
        endcase
    end

endmodule

// File: rtl/fwd_wb_unit.sv
// MEM/WB slot tracking, RF write port, ID forwarding and stalls.
// Optional FWD_STALL_CNT_EN adds a free-running stall cycle counter.
module fwd_wb_unit
    import fwd_wb_unit_pkg::*;
#(
    parameter int XLEN      = XLEN_D,
    parameter int NREG_BITS = NREG_BITS_D
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NREG_BITS-1:0] id_rs1_i,
    input  logic [NREG_BITS-1:0] id_rs2_i,
    input  logic                 ex_valid_i,
    input  logic [NREG_BITS-1:0] ex_rd_i,
    input  logic                 ex_we_i,
    input  logic                 ex_is_ld_i,
    input  logic                 ex_is_st_i,
    input  logic [2:0]           ex_funct3_i,
    input  logic [XLEN-1:0]      ex_dat_i,
    input  logic                 mem_ack_i,
    input  logic [XLEN-1:0]      mem_rdat_i,
    output logic                 is_fwd_a_o,
    output logic                 is_fwd_b_o,
    output logic [XLEN-1:0]      dat_fwd_a_o,
    output logic [XLEN-1:0]      dat_fwd_b_o,
    output logic [NREG_BITS-1:0] rd_o,
    output logic [XLEN-1:0]      rf_wd_o,
    output logic                 rf_we_o,
`ifdef FWD_STALL_CNT_EN
    output logic [31:0]          stall_cnt_o,
`endif
    output logic                 ld_use_stall_o,
    output logic                 mem_wait_o
);

    mem_slot_t       mem_q;
    wb_slot_t        wb_q;
    logic [XLEN-1:0] ld_dat;
    logic            ex_ok;
    logic            mem_ok;

    fwd_wb_unit_ld_align u_ld_align (
        .funct3 (mem_q.funct3),
        .off    (mem_q.dat[1:0]),
        .rdat   (mem_rdat_i),
        .dat    (ld_dat)
    );

    assign mem_wait_o = mem_q.v & (mem_q.ld | mem_q.st) & ~mem_ack_i;

    assign rf_we_o = wb_q.v & wb_q.we & (wb_q.rd != X0);
    assign rd_o    = wb_q.rd;
    assign rf_wd_o = wb_q.dat;

    // Loads in EX/MEM have no data yet, so they never forward
    assign ex_ok  = ex_valid_i & ex_we_i & ~ex_is_ld_i;
    assign mem_ok = mem_q.v & mem_q.we & ~mem_q.ld;

    function automatic logic [XLEN:0] fwd_pick(
        input logic [NREG_BITS-1:0] rs
    );
        logic [XLEN:0] r;
        r = '0;
        if (rs == X0)
            r = '0;
        else if (ex_ok && ex_rd_i == rs)
            r = {1'b1, ex_dat_i};
        else if (mem_ok && mem_q.rd == rs)
            r = {1'b1, mem_q.dat};
        else if (rf_we_o && wb_q.rd == rs)
            r = {1'b1, wb_q.dat};
        return r;
    endfunction

    always_comb begin
        {is_fwd_a_o, dat_fwd_a_o} = fwd_pick(id_rs1_i);
        {is_fwd_b_o, dat_fwd_b_o} = fwd_pick(id_rs2_i);
    end

    assign ld_use_stall_o = ~mem_wait_o & ex_valid_i & ex_is_ld_i
                          & ex_we_i & (ex_rd_i != X0)
                          & ((ex_rd_i == id_rs1_i)
                           | (ex_rd_i == id_rs2_i));

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!mem_wait_o) begin
            mem_q.v      <= ex_valid_i;
            mem_q.rd     <= ex_rd_i;
            mem_q.we     <= ex_we_i;
            mem_q.ld     <= ex_is_ld_i;
            mem_q.st     <= ex_is_st_i;
            mem_q.funct3 <= ex_funct3_i;
            mem_q.dat    <= ex_dat_i;
            wb_q.v       <= mem_q.v;
            wb_q.rd      <= mem_q.rd;
            wb_q.we      <= mem_q.we;
            wb_q.dat     <= mem_q.ld ? ld_dat : mem_q.dat;
        end else begin
            // WB already wrote once; keep it from repeating while MEM waits
            wb_q.v <= 1'b0;
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            stall_cnt_q <= '0;
        else if (ld_use_stall_o | mem_wait_o)
            stall_cnt_q <= stall_cnt_q + 32'd1;
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
